// File: rtl/seq_pkg.sv
// Shared definitions for the sequence player: colour width, the playback/check
// state encoding and a small helper used to size the display timer.
package seq_pkg;

    localparam int COLOR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        OFF   = 2'd2,
        CHECK = 2'd3
    } state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_if.sv
// Game-side bundle of the sequence player: control pulses and player guesses
// flow in, the displayed colour, status and result pulses flow out.
interface seq_if #(
    parameter int MAX_LEN = 32
) ();
    import seq_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               clear;
    logic               append;
    logic [COLOR_W-1:0] num;
    logic               guess_valid;
    logic [COLOR_W-1:0] guess;

    logic               show_valid;
    logic [COLOR_W-1:0] show_color;
    logic               busy;
    logic               play_done;
    logic               match;
    logic               mismatch;
    logic               round_won;
    logic [LEN_W-1:0]   length;
    logic               full;

    modport master (
        output clear, append, num, guess_valid, guess,
        input  show_valid, show_color, busy, play_done, match, mismatch,
               round_won, length, full
    );

    modport slave (
        input  clear, append, num, guess_valid, guess,
        output show_valid, show_color, busy, play_done, match, mismatch,
               round_won, length, full
    );

endinterface

// File: rtl/seq_mem.sv
// Colour store for the sequence: one synchronous write port used when a new
// element is appended, one combinational read port shared by playback and
// guess checking. Contents are deliberately left unreset.
module seq_mem
    import seq_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [COLOR_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [COLOR_W-1:0] o_rdata
);

    logic [COLOR_W-1:0] r_mem [DEPTH];

    // Capture a new colour on the write strobe; no reset, stale entries are
    // never read because the index is always below the stored length.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sequence_player.sv
// Simon-style sequence player: appends a colour, replays the whole stored
// sequence with timed on/off phases, then checks the player's guesses one
// element at a time and reports match/mismatch/round-won pulses.
module sequence_player
    import seq_pkg::*;
#(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic clock,
    input  logic reset,
    seq_if.slave bus
);

    localparam int ADDR_W  = $clog2(MAX_LEN);
    localparam int LEN_W   = ADDR_W + 1;
    localparam int TIMER_W = $clog2(maxOf(ON_CYCLES, OFF_CYCLES) + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [LEN_W-1:0]   r_length;
    logic [LEN_W-1:0]   w_nextLength;
    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W-1:0]  w_nextIdx;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_nextTimer;

    logic r_playDone;
    logic r_match;
    logic r_mismatch;
    logic r_roundWon;
    logic w_playDone;
    logic w_match;
    logic w_mismatch;
    logic w_roundWon;

    logic               w_we;
    logic [COLOR_W-1:0] w_memColor;
    logic               w_full;
    logic               w_lastIdx;
    logic               w_onDone;
    logic               w_offDone;

    seq_mem #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_length[ADDR_W-1:0]),
        .i_wdata (bus.num),
        .i_raddr (r_idx),
        .o_rdata (w_memColor)
    );

    assign w_full    = (r_length == LEN_W'(MAX_LEN));
    assign w_lastIdx = ({1'b0, r_idx} == (r_length - LEN_W'(1)));
    assign w_onDone  = (r_timer == TIMER_W'(ON_CYCLES - 1));
    assign w_offDone = (r_timer == TIMER_W'(OFF_CYCLES - 1));

    // Next-state logic: clear overrides everything, otherwise walk through
    // append -> timed playback -> guess checking. The timer is cleared on
    // every phase change so it never needs to wrap.
    always_comb begin
        w_nextState  = r_state;
        w_nextLength = r_length;
        w_nextIdx    = r_idx;
        w_nextTimer  = r_timer;
        w_we         = 1'b0;
        w_playDone   = 1'b0;
        w_match      = 1'b0;
        w_mismatch   = 1'b0;
        w_roundWon   = 1'b0;

        if (bus.clear) begin
            w_nextState  = IDLE;
            w_nextLength = '0;
            w_nextIdx    = '0;
            w_nextTimer  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.append) begin
                        if (!w_full) begin
                            w_we         = 1'b1;
                            w_nextLength = r_length + LEN_W'(1);
                        end
                        w_nextIdx   = '0;
                        w_nextTimer = '0;
                        w_nextState = ON;
                    end
                end
                ON: begin
                    if (w_onDone) begin
                        w_nextTimer = '0;
                        w_nextState = OFF;
                    end else begin
                        w_nextTimer = r_timer + TIMER_W'(1);
                    end
                end
                OFF: begin
                    if (w_offDone) begin
                        w_nextTimer = '0;
                        if (w_lastIdx) begin
                            w_playDone  = 1'b1;
                            w_nextIdx   = '0;
                            w_nextState = CHECK;
                        end else begin
                            w_nextIdx   = r_idx + ADDR_W'(1);
                            w_nextState = ON;
                        end
                    end else begin
                        w_nextTimer = r_timer + TIMER_W'(1);
                    end
                end
                CHECK: begin
                    if (bus.guess_valid) begin
                        if (bus.guess == w_memColor) begin
                            w_match = 1'b1;
                            if (w_lastIdx) begin
                                w_roundWon  = 1'b1;
                                w_nextIdx   = '0;
                                w_nextState = IDLE;
                            end else begin
                                w_nextIdx = r_idx + ADDR_W'(1);
                            end
                        end else begin
                            w_mismatch  = 1'b1;
                            w_nextIdx   = '0;
                            w_nextState = IDLE;
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State, counters and the registered one-cycle result pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_length   <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_playDone <= 1'b0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_roundWon <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_length   <= w_nextLength;
            r_idx      <= w_nextIdx;
            r_timer    <= w_nextTimer;
            r_playDone <= w_playDone;
            r_match    <= w_match;
            r_mismatch <= w_mismatch;
            r_roundWon <= w_roundWon;
        end
    end

    assign bus.show_valid = (r_state == ON);
    assign bus.show_color = (r_state == ON) ? w_memColor : '0;
    assign bus.busy       = (r_state != IDLE);
    assign bus.play_done  = r_playDone;
    assign bus.match      = r_match;
    assign bus.mismatch   = r_mismatch;
    assign bus.round_won  = r_roundWon;
    assign bus.length     = r_length;
    assign bus.full       = w_full;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for the sequence player with short display timings
// (3 cycles on, 2 cycles off) and a four-entry sequence store.
module tb_sequence_player;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    seq_if #(.MAX_LEN(4)) bus ();

    sequence_player #(
        .MAX_LEN    (4),
        .ON_CYCLES  (3),
        .OFF_CYCLES (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic a, input logic [1:0] n,
                                 input logic gv, input logic [1:0] g);
        bus.clear       = c;
        bus.append      = a;
        bus.num         = n;
        bus.guess_valid = gv;
        bus.guess       = g;
        step();
        bus.clear       = 1'b0;
        bus.append      = 1'b0;
        bus.guess_valid = 1'b0;
    endtask

    task automatic waitPlay(input string name);
        int n;
        n = 0;
        while (bus.play_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (bus.play_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s play_done timeout got %0b expected 1", name, bus.play_done);
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.clear       = 1'b0;
        bus.append      = 1'b0;
        bus.num         = 2'd0;
        bus.guess_valid = 1'b0;
        bus.guess       = 2'd0;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({bus.busy, bus.full, bus.show_valid, bus.show_color} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_status got %b expected 00000",
                     {bus.busy, bus.full, bus.show_valid, bus.show_color});
        end
        checks++;
        if (bus.length !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_length got %0d expected 0", bus.length);
        end
        checks++;
        if ({bus.play_done, bus.match, bus.mismatch, bus.round_won} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses got %b expected 0000",
                     {bus.play_done, bus.match, bus.mismatch, bus.round_won});
        end
    endtask

    task automatic test_single_append();
        applyStimulus(0, 1, 2'd2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.show_valid, bus.show_color} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL single_on%0d got %b expected 110", k,
                         {bus.show_valid, bus.show_color});
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({bus.busy, bus.show_valid, bus.show_color, bus.play_done} !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL single_off%0d got %b expected 10000", k,
                         {bus.busy, bus.show_valid, bus.show_color, bus.play_done});
            end
            step();
        end
        checks++;
        if ({bus.play_done, bus.length} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL single_done got %b expected 1001", {bus.play_done, bus.length});
        end
        applyStimulus(0, 0, 0, 1, 2'd2);
        checks++;
        if ({bus.match, bus.round_won, bus.mismatch, bus.busy} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL single_guess got %b expected 1100",
                     {bus.match, bus.round_won, bus.mismatch, bus.busy});
        end
    endtask

    task automatic test_rounds();
        logic [1:0] expSeq [3];
        expSeq = '{2'd1, 2'd3, 2'd0};
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 2'd1, 0, 0);
        waitPlay("rounds_r1");
        applyStimulus(0, 0, 0, 1, 2'd1);
        checks++;
        if ({bus.match, bus.round_won, bus.mismatch} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rounds_r1_guess got %b expected 110",
                     {bus.match, bus.round_won, bus.mismatch});
        end
        applyStimulus(0, 1, 2'd3, 0, 0);
        waitPlay("rounds_r2");
        applyStimulus(0, 0, 0, 1, 2'd1);
        checks++;
        if ({bus.match, bus.round_won, bus.mismatch} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rounds_r2_g0 got %b expected 100",
                     {bus.match, bus.round_won, bus.mismatch});
        end
        applyStimulus(0, 0, 0, 1, 2'd3);
        checks++;
        if ({bus.match, bus.round_won, bus.mismatch} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rounds_r2_g1 got %b expected 110",
                     {bus.match, bus.round_won, bus.mismatch});
        end
        applyStimulus(0, 1, 2'd0, 0, 0);
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({bus.show_valid, bus.show_color} !== {1'b1, expSeq[e]}) begin
                    errors++;
                    $display("[TB] FAIL rounds_show_e%0d_c%0d got %b expected %b", e, k,
                             {bus.show_valid, bus.show_color}, {1'b1, expSeq[e]});
                end
                step();
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({bus.show_valid, bus.show_color} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL rounds_blank_e%0d_c%0d got %b expected 000", e, k,
                             {bus.show_valid, bus.show_color});
                end
                step();
            end
        end
        checks++;
        if ({bus.play_done, bus.length} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL rounds_done got %b expected 1011", {bus.play_done, bus.length});
        end
        for (int g = 0; g < 3; g++) begin
            applyStimulus(0, 0, 0, 1, expSeq[g]);
            checks++;
            if ({bus.match, bus.round_won, bus.mismatch} !== {1'b1, (g == 2), 1'b0}) begin
                errors++;
                $display("[TB] FAIL rounds_r3_g%0d got %b expected %b", g,
                         {bus.match, bus.round_won, bus.mismatch}, {1'b1, (g == 2), 1'b0});
            end
        end
    endtask

    task automatic test_mismatch();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 2'd1, 0, 0);
        waitPlay("mismatch_r1");
        applyStimulus(0, 0, 0, 1, 2'd1);
        applyStimulus(0, 1, 2'd3, 0, 0);
        waitPlay("mismatch_r2");
        applyStimulus(0, 0, 0, 1, 2'd1);
        checks++;
        if ({bus.match, bus.mismatch} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL mismatch_first got %b expected 10", {bus.match, bus.mismatch});
        end
        applyStimulus(0, 0, 0, 1, 2'd2);
        checks++;
        if ({bus.match, bus.mismatch, bus.round_won, bus.busy, bus.length} !== 7'b0100010) begin
            errors++;
            $display("[TB] FAIL mismatch_second got %b expected 0100010",
                     {bus.match, bus.mismatch, bus.round_won, bus.busy, bus.length});
        end
        step();
        checks++;
        if (bus.mismatch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mismatch_width got %0b expected 0", bus.mismatch);
        end
    endtask

    task automatic test_ignored();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 2'd2, 0, 0);
        applyStimulus(0, 0, 0, 1, 2'd2);
        checks++;
        if ({bus.match, bus.mismatch} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ignored_guess got %b expected 00", {bus.match, bus.mismatch});
        end
        applyStimulus(0, 1, 2'd3, 0, 0);
        checks++;
        if (bus.length !== 3'd1) begin
            errors++;
            $display("[TB] FAIL ignored_append got %0d expected 1", bus.length);
        end
        waitPlay("ignored");
        applyStimulus(0, 0, 0, 1, 2'd2);
        checks++;
        if ({bus.match, bus.round_won} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL ignored_win got %b expected 11", {bus.match, bus.round_won});
        end
    endtask

    task automatic test_full();
        logic [1:0] nums [4];
        nums = '{2'd2, 2'd1, 2'd3, 2'd0};
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, nums[i], 0, 0);
            waitPlay("full_fill");
            applyStimulus(0, 0, 0, 1, 2'd3);
        end
        checks++;
        if ({bus.full, bus.length, bus.busy, bus.mismatch} !== 6'b110001) begin
            errors++;
            $display("[TB] FAIL full_status got %b expected 110001",
                     {bus.full, bus.length, bus.busy, bus.mismatch});
        end
        applyStimulus(0, 1, 2'd1, 0, 0);
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({bus.show_valid, bus.show_color} !== {1'b1, nums[e]}) begin
                    errors++;
                    $display("[TB] FAIL full_show_e%0d_c%0d got %b expected %b", e, k,
                             {bus.show_valid, bus.show_color}, {1'b1, nums[e]});
                end
                step();
            end
            step();
            step();
        end
        checks++;
        if ({bus.play_done, bus.length, bus.full} !== 5'b11001) begin
            errors++;
            $display("[TB] FAIL full_done got %b expected 11001",
                     {bus.play_done, bus.length, bus.full});
        end
        for (int g = 0; g < 4; g++) begin
            applyStimulus(0, 0, 0, 1, nums[g]);
            checks++;
            if ({bus.match, bus.round_won, bus.mismatch} !== {1'b1, (g == 3), 1'b0}) begin
                errors++;
                $display("[TB] FAIL full_guess%0d got %b expected %b", g,
                         {bus.match, bus.round_won, bus.mismatch}, {1'b1, (g == 3), 1'b0});
            end
        end
    endtask

    task automatic test_clear_priority();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 2'd3, 0, 0);
        step();
        step();
        applyStimulus(1, 1, 2'd1, 0, 0);
        checks++;
        if ({bus.busy, bus.length, bus.show_valid, bus.show_color} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL clear_mid_on got %b expected 0000000",
                     {bus.busy, bus.length, bus.show_valid, bus.show_color});
        end
        step();
        checks++;
        if ({bus.busy, bus.show_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clear_after got %b expected 00", {bus.busy, bus.show_valid});
        end
        applyStimulus(0, 1, 2'd1, 0, 0);
        waitPlay("clear_check");
        applyStimulus(1, 0, 0, 1, 2'd1);
        checks++;
        if ({bus.match, bus.round_won, bus.busy, bus.length} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL clear_vs_guess got %b expected 000000",
                     {bus.match, bus.round_won, bus.busy, bus.length});
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(0, 1, 2'd1, 0, 0);
        step();
        step();
        step();
        checks++;
        if ({bus.busy, bus.show_valid, bus.length} !== 5'b10001) begin
            errors++;
            $display("[TB] FAIL areset_pre got %b expected 10001",
                     {bus.busy, bus.show_valid, bus.length});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.show_valid, bus.show_color, bus.length, bus.full,
             bus.play_done, bus.match, bus.mismatch, bus.round_won} !== 12'b0) begin
            errors++;
            $display("[TB] FAIL areset_now got %b expected 000000000000",
                     {bus.busy, bus.show_valid, bus.show_color, bus.length, bus.full,
                      bus.play_done, bus.match, bus.mismatch, bus.round_won});
        end
        #2;
        reset = 1'b0;
        step();
        checks++;
        if ({bus.busy, bus.play_done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL areset_after got %b expected 00", {bus.busy, bus.play_done});
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_append();
        test_rounds();
        test_mismatch();
        test_ignored();
        test_full();
        test_clear_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter MAX_LEN, default 32: maximum stored sequence length (power of 2, ≥2).
REQ-002 Parameter ON_CYCLES, default 25_000_000: clock cycles each element is displayed.
REQ-003 Parameter OFF_CYCLES, default 12_500_000: blank clock cycles after each displayed element.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clear  in  1  synchronous new-game pulse; empties the sequence.
REQ-007 append  in  1  pulse; capture num as a new element, then play back the whole sequence.
REQ-008 num  in  2  random colour from the upstream 2-bit LFSR output.
REQ-009 guess_valid  in  1  player-input strobe, one cycle per guess.
REQ-010 guess  in  2  player colour; qualified by guess_valid.
REQ-011 show_valid  out  1  high while an element is displayed.
REQ-012 show_color  out  2  displayed colour; 0 when show_valid is low.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 play_done  out  1  one-cycle pulse at the end of playback.
REQ-015 match  out  1  one-cycle pulse for a correct guess.
REQ-016 mismatch  out  1  one-cycle pulse for a wrong guess.
REQ-017 round_won  out  1  one-cycle pulse when the whole sequence has been guessed correctly.
REQ-018 length  out  clog2(MAX_LEN)+1  number of stored elements.
REQ-019 full  out  1  high when length == MAX_LEN.

Function
REQ-020 The FSM SHALL have the states IDLE, ON, OFF and CHECK, plus an element index idx and a timer.
REQ-021 IDLE, append, !full: write mem[length]=num, length+1, idx=0, timer=0, go to ON.
REQ-022 IDLE, append, full: no write, length unchanged, idx=0, go to ON (replay only).
REQ-023 append is ignored outside IDLE.
REQ-024 guess_valid is ignored outside CHECK.
REQ-025 show_valid SHALL rise in the cycle after the edge that samples append.
REQ-026 ON: show_valid=1, show_color=mem[idx] for exactly ON_CYCLES cycles, then go to OFF with timer=0.
REQ-027 OFF: outputs blank for exactly OFF_CYCLES cycles.
REQ-028 At the end of OFF, if idx<length-1: idx+1, go to ON.
REQ-029 At the end of OFF, if idx==length-1: pulse play_done, idx=0, go to CHECK.
REQ-030 CHECK, guess_valid, guess==mem[idx], idx<length-1: pulse match, idx+1.
REQ-031 CHECK, guess_valid, guess==mem[idx], idx==length-1: pulse match and round_won in the same cycle, go to IDLE.
REQ-032 CHECK, guess_valid, guess!=mem[idx]: pulse mismatch, go to IDLE; length is retained.
REQ-033 All pulses (play_done, match, mismatch, round_won) SHALL be registered, one cycle wide, and asserted in the cycle after the causing edge.
REQ-034 clear in any state: go to IDLE, length=0, idx=0, timer=0, all outputs low next cycle.
REQ-035 clear SHALL take priority over append and guess_valid sampled in the same cycle.
REQ-036 The timer SHALL be wide enough for max(ON_CYCLES, OFF_CYCLES) and SHALL never wrap.
REQ-037 length SHALL saturate at MAX_LEN.

Reset
REQ-038 Asserting reset SHALL immediately force state=IDLE, length=0, idx=0, timer=0 and every output to 0, mid-playback included.
REQ-039 Memory contents are not reset; they are never read at index ≥ length.

Structure
REQ-040 Package seq_pkg SHALL hold the state encoding and COLOR_W=2.
REQ-041 Sub-module seq_mem SHALL be a MAX_LEN x COLOR_W register file with one synchronous write port and one combinational read port.

Verification (ON_CYCLES=3, OFF_CYCLES=2, MAX_LEN=4)
REQ-042 Append (num=2) -> show_valid high for 3 cycles starting at N+1, colour 2; 2 blank cycles; play_done; length=1.
REQ-043 Three rounds with num 1,3,0 -> third playback shows 1,3,0, each for 3 cycles; guesses 1,3,0 -> match x3 and round_won on the last guess.
REQ-044 Sequence 1,3; guesses 1,2 -> match then mismatch; back in IDLE; length stays 2.
REQ-045 Four appends, then append again -> full=1, length=4, replay of the 4 elements, no write.
REQ-046 clear asserted mid-ON, together with append -> next cycle IDLE, length=0, show_valid=0.
REQ-047 Async reset mid-OFF -> all outputs 0 immediately, busy=0.
